// File: rtl/imem_line_fetcher_pkg.sv
// imem_line_fetcher_pkg: line geometry and fetch FSM state encoding shared by the line fetcher.
// Revision: 1.0
`default_nettype none

package imem_line_fetcher_pkg;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BITS  = 128;
    localparam int TAG_BITS   = 28;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_line_buf.sv
// imem_line_buf: single-entry line buffer (tag, data, valid); flush beats a same-cycle write.
// Revision: 1.0
`default_nettype none

module imem_line_buf
    import imem_line_fetcher_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 flush,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_data,
    output logic                 valid,
    output logic [TAG_BITS-1:0]  tag,
    output logic [LINE_BITS-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (wr_en) begin
                valid <= 1'b1;
            end
            if (wr_en) begin
                tag  <= wr_tag;
                data <= wr_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_line_fetcher.sv
// imem_line_fetcher: fetches a 4-word instruction line over a pipelined word bus, with timeout abort.
// Optional one-line buffer enabled by defining IMEM_LINE_BUF_EN. Revision: 1.0
`default_nettype none

module imem_line_fetcher
    import imem_line_fetcher_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          req_addr_i,
    input  logic                 req_cs_i,
    input  logic                 req_we_i,
    input  logic                 flush_i,
    output logic [LINE_BITS-1:0] rsp_rdata_o,
    output logic                 rsp_rvalid_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 bus_req_o,
    output logic [31:0]          bus_addr_o,
    input  logic                 bus_gnt_i,
    input  logic                 bus_rvalid_i,
    input  logic [31:0]          bus_rdata_i,
    input  logic                 bus_err_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [31:0]            base;
    logic [2:0]             issue_cnt;
    logic [2:0]             recv_cnt;
    logic [TW-1:0]          tmo_cnt;
    logic                   err;
    logic [LINE_BITS-1:0]   line;

    logic                   in_fetch;
    logic                   gnt_ok;
    logic                   rsp_ok;
    logic                   issue_last;
    logic                   recv_last;
    logic                   tmo_hit;
    logic                   hit;
    logic [LINE_BITS-1:0]   buf_data;
    logic                   unused_bits;

    assign in_fetch   = (state == ST_ISSUE) || (state == ST_WAIT);
    assign gnt_ok     = (state == ST_ISSUE) && bus_gnt_i;
    assign rsp_ok     = in_fetch && bus_rvalid_i;
    assign issue_last = gnt_ok && (issue_cnt == 3'd3);
    assign recv_last  = rsp_ok && (recv_cnt == 3'd3);
    assign tmo_hit    = in_fetch && !gnt_ok && !rsp_ok && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef IMEM_LINE_BUF_EN
    logic                buf_valid;
    logic [TAG_BITS-1:0] buf_tag;

    imem_line_buf u_line_buf (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   ((state == ST_RESP) && !err),
        .flush   (flush_i),
        .wr_tag  (base[31:4]),
        .wr_data (line),
        .valid   (buf_valid),
        .tag     (buf_tag),
        .data    (buf_data)
    );

    assign hit         = buf_valid && (buf_tag == req_addr_i[31:4]);
    assign unused_bits = ^req_addr_i[3:0];
`else
    assign hit         = 1'b0;
    assign buf_data    = '0;
    assign unused_bits = ^{req_addr_i[3:0], flush_i};
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_cs_i) begin
                    state_nxt = (req_we_i || hit) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (recv_last || tmo_hit) begin
                    state_nxt = ST_RESP;
                end else if (issue_last) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (recv_last || tmo_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            tmo_cnt   <= '0;
            err       <= 1'b0;
            line      <= '0;
        end else if (state == ST_IDLE) begin
            if (req_cs_i) begin
                line <= '0;
                err  <= req_we_i;
                if (!req_we_i) begin
                    // Base is latched on hits too, so a buffer rewrite in RESP keeps a consistent tag.
                    base      <= {req_addr_i[31:4], 4'h0};
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                    tmo_cnt   <= '0;
                    if (hit) begin
                        line <= buf_data;
                    end
                end
            end
        end else if (in_fetch) begin
            if (gnt_ok) begin
                issue_cnt <= issue_cnt + 3'd1;
            end
            if (rsp_ok) begin
                line[{recv_cnt[1:0], 5'd0} +: 32] <= bus_err_i ? 32'h0 : bus_rdata_i;
                recv_cnt <= recv_cnt + 3'd1;
                if (bus_err_i) begin
                    err <= 1'b1;
                end
            end
            tmo_cnt <= (gnt_ok || rsp_ok) ? '0 : tmo_cnt + TW'(1);
            if (tmo_hit) begin
                line <= '0;
                err  <= 1'b1;
            end
        end
    end

    assign rsp_rdata_o  = line;
    assign rsp_rvalid_o = (state == ST_RESP);
    assign rsp_err_o    = (state == ST_RESP) && err;
    assign busy_o       = (state != ST_IDLE);
    assign bus_req_o    = (state == ST_ISSUE);
    assign bus_addr_o   = base + {27'd0, issue_cnt[1:0], 3'd0} - {28'd0, issue_cnt[1:0], 2'd0};

endmodule

`default_nettype wire

// File: tb/tb_imem_line_fetcher.sv
// tb_imem_line_fetcher: directed self-checking bench with a pipelined word-bus responder.
// Revision: 1.0
`default_nettype none

module tb_imem_line_fetcher;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  req_addr = '0;
    logic         req_cs = 1'b0;
    logic         req_we = 1'b0;
    logic         flush = 1'b0;
    logic [127:0] rsp_rdata;
    logic         rsp_rvalid;
    logic         rsp_err;
    logic         busy;
    logic         bus_req;
    logic [31:0]  bus_addr;
    logic         bus_gnt = 1'b0;
    logic         bus_rvalid = 1'b0;
    logic [31:0]  bus_rdata = '0;
    logic         bus_err = 1'b0;

    always #5 clk = ~clk;

    imem_line_fetcher #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_addr_i   (req_addr),
        .req_cs_i     (req_cs),
        .req_we_i     (req_we),
        .flush_i      (flush),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_rvalid_o (rsp_rvalid),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy),
        .bus_req_o    (bus_req),
        .bus_addr_o   (bus_addr),
        .bus_gnt_i    (bus_gnt),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .bus_err_i    (bus_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus responder: grant after gnt_delay waiting cycles, respond the cycle after the grant.
    int          gnt_delay = 0;
    bit          gnt_en = 1'b1;
    int          err_beat = -1;
    bit          inject_late = 1'b0;
    int          wait_cnt = 0;
    int          beat = 0;
    int          grants = 0;
    logic [31:0] gnt_addr = '0;
    logic [31:0] addr_q[$];

    initial begin
        forever begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            bus_rdata  = '0;
            if (bus_gnt) begin
                bus_rvalid = 1'b1;
                bus_rdata  = 32'h11 * (32'(gnt_addr[3:2]) + 32'd1);
                bus_err    = (beat == err_beat);
                beat++;
                grants++;
                addr_q.push_back(gnt_addr);
                wait_cnt = 0;
            end else if (inject_late) begin
                bus_rvalid  = 1'b1;
                bus_rdata   = 32'hDEAD_BEEF;
                inject_late = 1'b0;
            end
            if (gnt_en && bus_req && wait_cnt == gnt_delay) begin
                bus_gnt  = 1'b1;
                gnt_addr = bus_addr;
            end else begin
                bus_gnt = 1'b0;
                if (bus_req) wait_cnt++;
            end
        end
    end

    task automatic reset_model(input int d, input bit do_flush);
        gnt_delay = d;
        gnt_en    = 1'b1;
        err_beat  = -1;
        beat      = 0;
        grants    = 0;
        wait_cnt  = 0;
        addr_q.delete();
        flush = do_flush;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Called at a negedge; cycle 1 is the cycle after the edge that samples cs.
    task automatic do_fetch(input logic [31:0] addr, input logic we, output int lat,
                            output logic [127:0] data, output logic e, output int extra);
        req_addr = addr;
        req_cs   = 1'b1;
        req_we   = we;
        lat = 0; data = '0; e = 1'b0; extra = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (rsp_rvalid) begin
                lat  = i;
                data = rsp_rdata;
                e    = rsp_err;
                break;
            end
        end
        req_cs = 1'b0;
        req_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_rvalid) extra++;
        end
    endtask

    localparam logic [127:0] LINE_OK  = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] LINE_E2  = 128'h00000044_00000000_00000022_00000011;

    int           lat;
    int           extra;
    int           idle_bad;
    logic [127:0] data;
    logic         e;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req", bus_req, 0);
        check_eq("rst_rvalid", rsp_rvalid, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        check_eq("rst_addr", bus_addr, 0);

        // Zero-wait fetch, request accepted on the first edge after reset release
        reset_model(0, 1'b1);
        rst = 1'b0;
        do_fetch(32'h0000_1008, 1'b0, lat, data, e, extra);
        check_eq("zw_lat", lat, 6);
        check_eq("zw_data", data, LINE_OK);
        check_eq("zw_err", e, 0);
        check_eq("zw_extra", extra, 0);
        check_eq("zw_grants", grants, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("zw_addr%0d", i), addr_q[i], 32'h1000 + 32'(4 * i));
        end

        // Grants delayed 3 cycles per beat
        reset_model(3, 1'b1);
        do_fetch(32'h0000_1000, 1'b0, lat, data, e, extra);
        check_eq("dly_lat", lat, 18);
        check_eq("dly_data", data, LINE_OK);
        check_eq("dly_err", e, 0);
        check_eq("dly_extra", extra, 0);
        check_eq("dly_grants", grants, 4);

        // Error on third response
        reset_model(0, 1'b1);
        err_beat = 2;
        do_fetch(32'h0000_100C, 1'b0, lat, data, e, extra);
        check_eq("err_lat", lat, 6);
        check_eq("err_data", data, LINE_E2);
        check_eq("err_err", e, 1);
        reset_model(0, 1'b0);
        do_fetch(32'h0000_1000, 1'b0, lat, data, e, extra);
        check_eq("err_nobuf_grants", grants, 4);
        check_eq("err_nobuf_data", data, LINE_OK);
        check_eq("err_nobuf_err", e, 0);

        // Write request
        reset_model(0, 1'b1);
        do_fetch(32'h0000_3000, 1'b1, lat, data, e, extra);
        check_eq("wr_lat", lat, 1);
        check_eq("wr_err", e, 1);
        check_eq("wr_data", data, 0);
        check_eq("wr_grants", grants, 0);

        // Timeout with no grants, then a late response in IDLE
        reset_model(0, 1'b1);
        gnt_en = 1'b0;
        do_fetch(32'h0000_2000, 1'b0, lat, data, e, extra);
        check_eq("tmo_lat", lat, 9);
        check_eq("tmo_err", e, 1);
        check_eq("tmo_data", data, 0);
        check_eq("tmo_grants", grants, 0);
        inject_late = 1'b1;
        idle_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || rsp_rvalid) idle_bad++;
        end
        check_eq("late_ignored", idle_bad, 0);
        check_eq("late_rdata", rsp_rdata, 0);

        // Reset after two grants
        reset_model(0, 1'b1);
        req_addr = 32'h0000_1000;
        req_cs   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("mid_grants", grants, 2);
        check_eq("mid_req_before", bus_req, 1);
        rst    = 1'b1;
        req_cs = 1'b0;
        #1;
        check_eq("mid_busy", busy, 0);
        check_eq("mid_req", bus_req, 0);
        check_eq("mid_rdata", rsp_rdata, 0);
        check_eq("mid_rvalid", rsp_rvalid, 0);
        repeat (2) @(negedge clk);
        reset_model(0, 1'b1);
        rst = 1'b0;
        do_fetch(32'h0000_1004, 1'b0, lat, data, e, extra);
        check_eq("post_lat", lat, 6);
        check_eq("post_data", data, LINE_OK);
        check_eq("post_grants", grants, 4);

`ifdef IMEM_LINE_BUF_EN
        reset_model(0, 1'b1);
        do_fetch(32'h0000_1000, 1'b0, lat, data, e, extra);
        check_eq("buf_fill_lat", lat, 6);
        reset_model(0, 1'b0);
        do_fetch(32'h0000_1000, 1'b0, lat, data, e, extra);
        check_eq("buf_hit_lat", lat, 1);
        check_eq("buf_hit_data", data, LINE_OK);
        check_eq("buf_hit_grants", grants, 0);
        reset_model(0, 1'b1);
        do_fetch(32'h0000_1000, 1'b0, lat, data, e, extra);
        check_eq("buf_flush_lat", lat, 6);
        check_eq("buf_flush_grants", grants, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
